countdown_timer: RTL and testbench

- Loadable synchronous down-counter timer; the down-counting counterpart of the team's free-running ripple up-counter.
- Accepts a start value through a valid/ready load handshake and decrements once every (prescale+1) clocks.
- Signals expiry with a one-cycle done pulse and optionally auto-reloads.
- Sits beside the up-counter in the user design as the timeout/interval source for downstream logic.

---
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counting timer: start value accepted on a valid/ready handshake,
// one decrement every (prescale+1) clocks, one-cycle done strobe, optional auto-reload.
module countdown_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  auto_reload,
  input  logic                  abort,
  output logic [WIDTH-1:0]      current_count,
  output logic                  busy,
  output logic                  done_pulse
);

  // Handshake: a load transfers on any rising edge where load_valid && load_ready;
  // load_ready is high only in IDLE, and load_valid in RUN is dropped, never queued.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      reload_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  ar_q;
  logic                  done_q;
  logic                  load_fire;
  logic                  tick;
  logic                  last_tick;

  assign load_fire = load_valid && (state_q == IDLE);
  assign tick      = (state_q == RUN) && (pre_q == p_q);
  assign last_tick = tick && (count_q == WIDTH'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort outranks a coincident tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_fire && (load_value != '0)) state_d = RUN;
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (last_tick && !ar_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready    = (state_q == IDLE);
    busy          = (state_q == RUN);
    current_count = count_q;
    done_pulse    = done_q;
  end

  // Datapath: count, prescaler and captured load parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      p_q      <= '0;
      ar_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (load_fire) begin
          count_q  <= load_value;
          reload_q <= load_value;
          p_q      <= prescale;
          ar_q     <= auto_reload;
          pre_q    <= '0;
          done_q   <= (load_value == '0);
        end
      end else if (abort) begin
        pre_q <= '0;
      end else if (tick) begin
        pre_q <= '0;
        if (count_q > WIDTH'(1)) begin
          count_q <= count_q - WIDTH'(1);
        end else if (last_tick) begin
          done_q  <= 1'b1;
          count_q <= ar_q ? reload_q : '0;
        end
      end else begin
        pre_q <= pre_q + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=8, PRESCALE_W=4).
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic [3:0] prescale;
  logic       auto_reload;
  logic       abort;
  logic [7:0] current_count;
  logic       busy;
  logic       done_pulse;

  int checks;
  int failures;

  countdown_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .prescale      (prescale),
    .auto_reload   (auto_reload),
    .abort         (abort),
    .current_count (current_count),
    .busy          (busy),
    .done_pulse    (done_pulse)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: advance one edge and settle, set up a load
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [7:0] v, input logic [3:0] p, input logic ar);
    load_valid  = 1'b1;
    load_value  = v;
    prescale    = p;
    auto_reload = ar;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] cnt, input logic b,
                         input logic d, input logic rdy);
    chk({tag, ".count"}, 32'(current_count), 32'(cnt));
    chk({tag, ".busy"},  32'(busy),          32'(b));
    chk({tag, ".done"},  32'(done_pulse),    32'(d));
    chk({tag, ".ready"}, 32'(load_ready),    32'(rdy));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_value  = '0;
    prescale    = '0;
    auto_reload = 1'b0;
    abort       = 1'b0;

    // Reset state
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk_all("post_reset", 8'd0, 1'b0, 1'b0, 1'b1);

    // Basic run: load 5, P=0
    drive_load(8'd5, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    chk_all("basic.E", 8'd5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all("basic.run", 8'(5 - k), (k < 5), (k == 5), (k == 5));
    end
    step();
    chk_all("basic.after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Prescale: load 3, P=2 -> steps every 3 cycles, expiry at E+9
    drive_load(8'd3, 4'd2, 1'b0);
    step();
    load_valid = 1'b0;
    chk_all("pre.E", 8'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all("pre.run", 8'(3 - k / 3), (k < 9), (k == 9), (k == 9));
    end
    step();
    chk("pre.done_clear", 32'(done_pulse), 32'd0);

    // Auto-reload: load 2, P=1 -> expiries at E+4, E+8, E+12
    drive_load(8'd2, 4'd1, 1'b1);
    step();
    load_valid = 1'b0;
    chk_all("ar.E", 8'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_all("ar.run", ((k / 2) % 2 == 1) ? 8'd1 : 8'd2, 1'b1, (k % 4 == 0), 1'b0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("ar.abort", 8'd2, 1'b0, 1'b0, 1'b1);

    // Zero load: immediate done, never busy
    drive_load(8'd0, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    chk_all("zero.E", 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("zero.after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Load 4, then hold load_valid with 9 while running: ignored
    drive_load(8'd4, 4'd0, 1'b0);
    step();
    load_value = 8'd9;
    chk_all("ign.E", 8'd4, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all("ign.run", 8'(4 - k), (k < 4), (k == 4), (k == 4));
    end
    load_valid = 1'b0;
    step();
    chk_all("ign.after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Abort at count 6
    drive_load(8'd10, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk_all("abort.pre", 8'd6, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("abort.E", 8'd6, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("abort.hold", 8'd6, 1'b0, 1'b0, 1'b1);

    // Abort coinciding with the final tick wins: no done
    drive_load(8'd2, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    step();
    chk_all("abort_tick.pre", 8'd1, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("abort_tick.E", 8'd1, 1'b0, 1'b0, 1'b1);
    step();
    chk("abort_tick.no_done", 32'(done_pulse), 32'd0);

    // Abort in IDLE is ignored; simultaneous load accepted
    drive_load(8'd3, 4'd0, 1'b0);
    abort = 1'b1;
    step();
    abort      = 1'b0;
    load_valid = 1'b0;
    chk_all("idle_abort.E", 8'd3, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    chk_all("idle_abort.exp", 8'd0, 1'b0, 1'b1, 1'b1);

    // N=1, P=0, auto-reload: done every cycle
    drive_load(8'd1, 4'd0, 1'b1);
    step();
    load_valid = 1'b0;
    chk_all("n1.E", 8'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all("n1.run", 8'd1, 1'b1, 1'b1, 1'b0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("n1.abort", 8'd1, 1'b0, 1'b0, 1'b1);

    // Maximum load value
    drive_load(8'd255, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    chk_all("max.E", 8'd255, 1'b1, 1'b0, 1'b0);
    step();
    chk("max.dec", 32'(current_count), 32'd254);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Async reset mid-run at count 7
    drive_load(8'd9, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    step();
    step();
    chk_all("rst.pre", 8'd7, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst.async", 8'd0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    drive_load(8'd1, 4'd0, 1'b0);
    step();
    load_valid = 1'b0;
    chk_all("rst.reload", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rst.exp", 8'd0, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
